// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Program-counter-driven sequencer. It fetches 16-bit instructions from a
//   synchronous ROM, decodes them, and drives the systolic-array strobes for
//   the correct number of cycles together with the matching memory address.
//
// Ports
//   clk          : rising-edge clock
//   reset        : synchronous, active-high reset
//   start        : begin execution at pc=0 (sampled only in IDLE)
//   hold         : stalls EXEC; strobes low, row counter frozen
//   imem_addr    : instruction ROM address (current pc)
//   imem_data    : ROM read data, valid one cycle after imem_addr
//   base_address : current base address register
//   mem_addr     : base_address + row counter, modulo 2^13
//   load_weight  : weight-row strobe
//   load_input   : activation-row strobe
//   valid        : compute enable to the array
//   busy         : high in every state except IDLE
//   done         : one-cycle pulse on program end
//   error        : sticky illegal-opcode flag, cleared by an accepted start
module instruction_sequencer #(
  parameter int ARRAY_N        = 2,
  parameter int COMPUTE_CYCLES = 4,
  parameter int PC_W           = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            hold,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [12:0]     base_address,
  output logic [12:0]     mem_addr,
  output logic            load_weight,
  output logic            load_input,
  output logic            valid,
  output logic            busy,
  output logic            done,
  output logic            error
);

  localparam int CNT_W = 16;

  localparam logic [2:0] OP_NOP       = 3'b000;
  localparam logic [2:0] OP_LOAD_ADDR = 3'b001;
  localparam logic [2:0] OP_LOAD_W    = 3'b010;
  localparam logic [2:0] OP_LOAD_I    = 3'b011;
  localparam logic [2:0] OP_COMPUTE   = 3'b100;
  localparam logic [2:0] OP_HALT      = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2,
    ST_EXEC   = 2'd3
  } state_t;

  state_t            state_r, state_s;
  logic [PC_W-1:0]   pc_r, pc_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s, term_s;
  logic [2:0]        opcode_r, opcode_s, dec_op_s;
  logic [12:0]       base_r, base_s;
  logic              done_r, done_s;
  logic              error_r, error_s;
  logic              exec_act_s;

  assign dec_op_s   = imem_data[15:13];
  // Last count value of the multi-cycle instruction currently in EXEC.
  assign term_s     = (opcode_r == OP_COMPUTE) ? CNT_W'(COMPUTE_CYCLES - 1)
                                               : CNT_W'(ARRAY_N - 1);
  assign exec_act_s = (state_r == ST_EXEC) && !hold;

  // The ROM address is the pc itself, so the word is ready in DECODE.
  assign imem_addr    = pc_r;
  assign base_address = base_r;
  assign mem_addr     = base_r + cnt_r[12:0];
  // Strobes depend on hold in the same cycle so a stall drops them at once.
  assign load_weight  = exec_act_s && (opcode_r == OP_LOAD_W);
  assign load_input   = exec_act_s && (opcode_r == OP_LOAD_I);
  assign valid        = exec_act_s && (opcode_r == OP_COMPUTE);
  assign busy         = (state_r != ST_IDLE);
  assign done         = done_r;
  assign error        = error_r;

  // Next-state and next-register-value logic for the sequencer FSM.
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    cnt_s    = cnt_r;
    opcode_s = opcode_r;
    base_s   = base_r;
    done_s   = 1'b0;
    error_s  = error_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_FETCH;
          pc_s    = {PC_W{1'b0}};
          error_s = 1'b0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        case (dec_op_s)
          OP_NOP: begin
            state_s = ST_FETCH;
            pc_s    = pc_r + PC_W'(1);
          end
          OP_LOAD_ADDR: begin
            base_s  = imem_data[12:0];
            state_s = ST_FETCH;
            pc_s    = pc_r + PC_W'(1);
          end
          OP_LOAD_W, OP_LOAD_I, OP_COMPUTE: begin
            opcode_s = dec_op_s;
            cnt_s    = {CNT_W{1'b0}};
            state_s  = ST_EXEC;
          end
          OP_HALT: begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end
          default: begin
            // Illegal opcode: flag it and end the program like a HALT.
            error_s = 1'b1;
            state_s = ST_IDLE;
            done_s  = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        if (hold) begin
          state_s = ST_EXEC;
        end else if (cnt_r == term_s) begin
          state_s = ST_FETCH;
          pc_s    = pc_r + PC_W'(1);
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      pc_r     <= {PC_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      opcode_r <= OP_NOP;
      base_r   <= 13'h0000;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      cnt_r    <= cnt_s;
      opcode_r <= opcode_s;
      base_r   <= base_s;
      done_r   <= done_s;
      error_r  <= error_s;
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Testbench for instruction_sequencer: table of per-cycle stimulus and
// expected outputs, applied in a loop through an expectation queue.
module tb_instruction_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hold = 1'b0;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic [12:0] base_address;
  logic [12:0] mem_addr;
  logic        load_weight, load_input, valid, busy, done, error;

  int rom_sel = 0;
  logic [15:0] rom_mem [0:2][0:7];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          rom;
    logic        reset, start, hold;
    logic        chk;
    logic        lw, li, vl, busy, done, err;
    logic [12:0] base;
    logic        chk_m;
    logic [12:0] maddr;
    logic        chk_i;
    logic [7:0]  iaddr;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  instruction_sequencer #(.ARRAY_N(2), .COMPUTE_CYCLES(4), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .base_address(base_address), .mem_addr(mem_addr),
    .load_weight(load_weight), .load_input(load_input), .valid(valid),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data one cycle after the address.
  always @(posedge clk) imem_data <= rom_mem[rom_sel][imem_addr[2:0]];

  function automatic vec_t blank_vec(input int rom);
    vec_t v;
    v.rom = rom; v.reset = 1'b0; v.start = 1'b0; v.hold = 1'b0; v.chk = 1'b1;
    v.lw = 1'b0; v.li = 1'b0; v.vl = 1'b0; v.busy = 1'b0; v.done = 1'b0;
    v.err = 1'b0; v.base = 13'h0000; v.chk_m = 1'b0; v.maddr = 13'h0000;
    v.chk_i = 1'b0; v.iaddr = 8'h00;
    return v;
  endfunction

  task automatic add_reset();
    vec_t v;
    v = blank_vec(0);
    v.reset = 1'b1;
    v.chk = 1'b0;
    vecs.push_back(v);
  endtask

  // Main program: LOAD_ADDR 0x20, LOAD_WEIGHT, LOAD_INPUT, COMPUTE, HALT.
  // Cycle numbers follow the reference timeline; a hold shifts later events.
  task automatic add_main(input logic err0, input int hold_at, input int reset_at,
                          input logic busy_starts, input logic fresh);
    int n;
    n = (hold_at >= 0) ? 23 : 22;
    for (int c = 0; c < n; c++) begin
      vec_t v;
      int e;
      logic held;
      held = (hold_at >= 0) && (c == hold_at);
      e = (hold_at >= 0 && c > hold_at) ? c - 1 : c;
      v = blank_vec(0);
      v.start = (c == 0) || (busy_starts && (c == 3 || c == 8 || c == 14));
      v.hold  = held || (hold_at >= 0 && (c == 2 || c == 20));
      v.lw    = !held && (e == 5 || e == 6);
      v.li    = (e == 9 || e == 10);
      v.vl    = (e >= 13 && e <= 16);
      v.busy  = (e >= 1 && e <= 18);
      v.done  = (e == 19);
      v.err   = (c == 0) ? err0 : 1'b0;
      v.base  = (e >= 3) ? 13'h020 : 13'h000;
      if (e == 5 || e == 6) begin
        v.chk_m = 1'b1; v.maddr = 13'h020 + 13'(e - 5);
      end else if (e == 9 || e == 10) begin
        v.chk_m = 1'b1; v.maddr = 13'h020 + 13'(e - 9);
      end else if (c == 0 && fresh) begin
        v.chk_m = 1'b1; v.maddr = 13'h000;
      end else begin
        v.chk_m = 1'b0;
      end
      case (e)
        0:  begin v.chk_i = fresh; v.iaddr = 8'd0; end
        1:  begin v.chk_i = 1'b1; v.iaddr = 8'd0; end
        3:  begin v.chk_i = 1'b1; v.iaddr = 8'd1; end
        7:  begin v.chk_i = 1'b1; v.iaddr = 8'd2; end
        11: begin v.chk_i = 1'b1; v.iaddr = 8'd3; end
        17: begin v.chk_i = 1'b1; v.iaddr = 8'd4; end
        default: v.chk_i = 1'b0;
      endcase
      v.reset = (c == reset_at);
      vecs.push_back(v);
      if (c == reset_at) begin
        v = blank_vec(0);
        v.chk_m = 1'b1; v.maddr = 13'h000;
        v.chk_i = 1'b1; v.iaddr = 8'd0;
        vecs.push_back(v);
        break;
      end
    end
  endtask

  // Base 0x1FFF: weight rows must wrap to 0x0000.
  task automatic add_wrap();
    for (int c = 0; c < 11; c++) begin
      vec_t v;
      v = blank_vec(1);
      v.start = (c == 0);
      v.lw    = (c == 5 || c == 6);
      v.busy  = (c >= 1 && c <= 8);
      v.done  = (c == 9);
      v.base  = (c >= 3) ? 13'h1FFF : 13'h0000;
      if (c == 5) begin v.chk_m = 1'b1; v.maddr = 13'h1FFF; end
      if (c == 6) begin v.chk_m = 1'b1; v.maddr = 13'h0000; end
      if (c == 1) begin v.chk_i = 1'b1; v.iaddr = 8'd0; end
      if (c == 3) begin v.chk_i = 1'b1; v.iaddr = 8'd1; end
      if (c == 7) begin v.chk_i = 1'b1; v.iaddr = 8'd2; end
      vecs.push_back(v);
    end
  endtask

  // NOP then illegal opcode 101: error plus done pulse, no strobes.
  task automatic add_illegal();
    for (int c = 0; c < 7; c++) begin
      vec_t v;
      v = blank_vec(2);
      v.start = (c == 0);
      v.busy  = (c >= 1 && c <= 4);
      v.done  = (c == 5);
      v.err   = (c >= 5);
      if (c == 1) begin v.chk_i = 1'b1; v.iaddr = 8'd0; end
      if (c == 3) begin v.chk_i = 1'b1; v.iaddr = 8'd1; end
      vecs.push_back(v);
    end
  endtask

  task automatic cmp(input string name, input int cyc, input logic [15:0] act,
                     input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  initial begin
    vec_t v, e;
    for (int p = 0; p < 3; p++)
      for (int a = 0; a < 8; a++)
        rom_mem[p][a] = 16'h0000;
    rom_mem[0][0] = 16'h2020; rom_mem[0][1] = 16'h4000; rom_mem[0][2] = 16'h6000;
    rom_mem[0][3] = 16'h8000; rom_mem[0][4] = 16'hE000;
    rom_mem[1][0] = 16'h3FFF; rom_mem[1][1] = 16'h4000; rom_mem[1][2] = 16'hE000;
    rom_mem[2][0] = 16'h0000; rom_mem[2][1] = 16'hA000;

    add_reset(); add_main(1'b0, -1, -1, 1'b0, 1'b1);
    add_reset(); add_main(1'b0,  6, -1, 1'b0, 1'b1);
    add_reset(); add_wrap();
    add_reset(); add_illegal(); add_main(1'b1, -1, -1, 1'b0, 1'b0);
    add_reset(); add_main(1'b0, -1, 14, 1'b0, 1'b1); add_main(1'b0, -1, -1, 1'b0, 1'b0);
    add_reset(); add_main(1'b0, -1, -1, 1'b1, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      v = vecs[i];
      reset   = v.reset;
      start   = v.start;
      hold    = v.hold;
      rom_sel = v.rom;
      exp_q.push_back(v);
      @(negedge clk);
      e = exp_q.pop_front();
      if (e.chk) begin
        cmp("load_weight",  i, 16'(load_weight),  16'(e.lw));
        cmp("load_input",   i, 16'(load_input),   16'(e.li));
        cmp("valid",        i, 16'(valid),        16'(e.vl));
        cmp("busy",         i, 16'(busy),         16'(e.busy));
        cmp("done",         i, 16'(done),         16'(e.done));
        cmp("error",        i, 16'(error),        16'(e.err));
        cmp("base_address", i, 16'(base_address), 16'(e.base));
        if (e.chk_m) cmp("mem_addr",  i, 16'(mem_addr),  16'(e.maddr));
        if (e.chk_i) cmp("imem_addr", i, 16'(imem_addr), 16'(e.iaddr));
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
